// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe.
// Request: A, B, ALU_FUN, IN_Valid / IN_Ready.
// Response: ALU_OUT, FLAGS, OUT_Valid / OUT_Ready.
// The master is the requester and consumer; the slave is the ALU.
interface alu_pipe_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
);
    logic [DATA_WIDTH-1:0]   A;
    logic [DATA_WIDTH-1:0]   B;
    logic [FUN_WIDTH-1:0]    ALU_FUN;
    logic                    IN_Valid;
    logic                    IN_Ready;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic [2:0]              FLAGS;
    logic                    OUT_Valid;
    logic                    OUT_Ready;

    modport master (
        output A, B, ALU_FUN, IN_Valid, OUT_Ready,
        input  IN_Ready, ALU_OUT, FLAGS, OUT_Valid
    );

    modport slave (
        input  A, B, ALU_FUN, IN_Valid, OUT_Ready,
        output IN_Ready, ALU_OUT, FLAGS, OUT_Valid
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with a one-entry result register and an iterative divider.
// Ports: CLK, RST (sync, active-high), bus (alu_pipe_if.slave).
module alu_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    alu_pipe_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    logic [2*W-1:0] out_q, out_d;
    logic [2:0]     flags_q, flags_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [3:0]     fn;
    logic           in_rdy;
    logic           accept;
    logic           is_nop;
    logic           div_go;
    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] prod;
    logic [2*W-1:0] res;
    logic           carry;
    logic           dz;
    logic [W:0]     shl;
    logic           ge;
    logic [W:0]     trial;
    logic [W-1:0]   rem_nx;
    logic [W-1:0]   quo_nx;

    assign fn     = bus.ALU_FUN[3:0];
    assign in_rdy = !RST && state_q != S_DIV
                    && (state_q != S_HOLD || bus.OUT_Ready);
    assign accept = bus.IN_Valid && in_rdy;
    assign is_nop = fn == 4'h8;
    assign div_go = fn == 4'h3 && bus.B != '0;

    // Single-cycle operations, evaluated on the request operands.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        dz    = 1'b0;
        sum   = {1'b0, bus.A} + {1'b0, bus.B};
        diff  = {1'b0, bus.A} - {1'b0, bus.B};
        prod  = {{W{1'b0}}, bus.A} * {{W{1'b0}}, bus.B};
        case (fn)
            4'h0: begin
                res[W:0] = sum;
                carry    = sum[W];
            end
            4'h1: begin
                res[W:0] = diff;
                carry    = bus.A < bus.B;
            end
            4'h2: res = prod;
            // Only reaches the result path for a zero divisor.
            4'h3: begin
                res = {bus.A, {W{1'b1}}};
                dz  = 1'b1;
            end
            4'h4: res[W-1:0] = bus.A & bus.B;
            4'h5: res[W-1:0] = bus.A | bus.B;
            4'h6: res[W-1:0] = ~(bus.A & bus.B);
            4'h7: res[W-1:0] = ~(bus.A | bus.B);
            4'h8: res = '0;
            4'h9: res[0] = bus.A == bus.B;
            4'hA: res[0] = bus.A > bus.B;
            4'hB: res[0] = bus.A < bus.B;
            4'hC: res[W-1:0] = bus.A >> 1;
            4'hD: res[W:0] = {bus.A, 1'b0};
            4'hE: res[W-1:0] = bus.B >> 1;
            4'hF: res[W:0] = {bus.B, 1'b0};
            default: res = '0;
        endcase
    end

    // One restoring-division step: shift in the next dividend bit,
    // subtract the divisor if it fits.
    always_comb begin
        shl    = {rem_q, quo_q[W-1]};
        ge     = shl >= {1'b0, dvs_q};
        trial  = shl - {1'b0, dvs_q};
        rem_nx = ge ? trial[W-1:0] : shl[W-1:0];
        quo_nx = {quo_q[W-2:0], ge};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_DIV: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                if (accept) begin
                    if (div_go) begin
                        state_d = S_DIV;
                    end else if (is_nop) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else if (state_q == S_HOLD && bus.OUT_Ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        bus.IN_Ready  = in_rdy;
        bus.OUT_Valid = state_q == S_HOLD;
        bus.ALU_OUT   = out_q;
        bus.FLAGS     = flags_q;
    end

    always_comb begin
        out_d   = out_q;
        flags_d = flags_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        if (state_q == S_DIV) begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                out_d   = {rem_nx, quo_nx};
                flags_d = {2'b00, {rem_nx, quo_nx} == '0};
            end
        end else if (accept) begin
            if (div_go) begin
                rem_d = '0;
                quo_d = bus.A;
                dvs_d = bus.B;
                cnt_d = CW'(W);
            end else if (!is_nop) begin
                out_d   = res;
                flags_d = {dz, carry, res == '0};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            flags_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe with W=8.
// Driver queues expected results; a negedge monitor pops and compares.
module tb_alu_pipe;
    localparam int W = 8;

    logic clk;
    logic rst;

    alu_pipe_if #(.DATA_WIDTH(W), .FUN_WIDTH(4)) bus ();

    alu_pipe #(.DATA_WIDTH(W), .FUN_WIDTH(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2*W-1:0] out;
        logic [2:0]     fl;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: a result is consumed on the next edge when valid&ready.
    logic           hold_p = 1'b0;
    logic [2*W-1:0] hold_out;
    logic [2:0]     hold_fl;

    always @(negedge clk) begin
        exp_t e;
        if (hold_p) begin
            chk("hold_valid", 32'(bus.OUT_Valid), 32'd1);
            chk("hold_out", 32'(bus.ALU_OUT), 32'(hold_out));
            chk("hold_flags", 32'(bus.FLAGS), 32'(hold_fl));
        end
        hold_p   = !rst && bus.OUT_Valid && !bus.OUT_Ready;
        hold_out = bus.ALU_OUT;
        hold_fl  = bus.FLAGS;
        if (!rst && bus.OUT_Valid && bus.OUT_Ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got=%h want=none",
                         bus.ALU_OUT);
            end else begin
                e = exp_q.pop_front();
                if (bus.ALU_OUT !== e.out || bus.FLAGS !== e.fl) begin
                    bad++;
                    $display("FAIL result got=%h/%b want=%h/%b",
                             bus.ALU_OUT, bus.FLAGS, e.out, e.fl);
                end
            end
        end
    end

    task automatic issue(logic [3:0] op, logic [W-1:0] a,
                         logic [W-1:0] b, bit ev,
                         logic [2*W-1:0] eo, logic [2:0] ef);
        int n = 0;
        @(negedge clk);
        bus.ALU_FUN  = op;
        bus.A        = a;
        bus.B        = b;
        bus.IN_Valid = 1'b1;
        while (!bus.IN_Ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.IN_Ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got=0 want=1");
        end
        if (ev) exp_q.push_back('{out: eo, fl: ef});
        @(posedge clk);
        #1 bus.IN_Valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALU_FUN   = '0;
        bus.IN_Valid  = 1'b0;
        bus.OUT_Ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.IN_Ready), 32'd0);
        chk("rst_out_valid", 32'(bus.OUT_Valid), 32'd0);
        chk("rst_out", 32'(bus.ALU_OUT), 32'd0);
        chk("rst_flags", 32'(bus.FLAGS), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.IN_Ready), 32'd1);

        issue(4'h0, 8'd250, 8'd10, 1, 16'h0104, 3'b010);
        chk("add_latency", 32'(bus.OUT_Valid), 32'd1);
        issue(4'h0, 8'd0, 8'd0, 1, 16'h0000, 3'b001);
        issue(4'h1, 8'd3, 8'd5, 1, 16'h01FE, 3'b010);
        issue(4'h2, 8'd255, 8'd255, 1, 16'hFE01, 3'b000);
        issue(4'h9, 8'd10, 8'd10, 1, 16'h0001, 3'b000);
        issue(4'h4, 8'hF0, 8'h0F, 1, 16'h0000, 3'b001);
        issue(4'h5, 8'hA0, 8'h05, 1, 16'h00A5, 3'b000);
        issue(4'h6, 8'hF0, 8'h3C, 1, 16'h00CF, 3'b000);
        issue(4'h7, 8'h0F, 8'h30, 1, 16'h00C0, 3'b000);
        issue(4'hA, 8'd9, 8'd3, 1, 16'h0001, 3'b000);
        issue(4'hB, 8'd9, 8'd3, 1, 16'h0000, 3'b001);
        issue(4'hC, 8'h81, 8'h00, 1, 16'h0040, 3'b000);
        issue(4'hD, 8'h81, 8'h00, 1, 16'h0102, 3'b000);
        issue(4'hE, 8'h00, 8'h02, 1, 16'h0001, 3'b000);
        issue(4'hF, 8'h00, 8'h80, 1, 16'h0100, 3'b000);

        // NOP yields no result.
        repeat (2) @(posedge clk);
        issue(4'h8, 8'd1, 8'd2, 0, '0, '0);
        chk("nop_no_valid", 32'(bus.OUT_Valid), 32'd0);

        // Iterative divide: W busy cycles, result on cycle W+1.
        issue(4'h3, 8'd100, 8'd7, 1, 16'h020E, 3'b000);
        for (int i = 0; i < W; i++) begin
            chk("div_busy_ready", 32'(bus.IN_Ready), 32'd0);
            chk("div_busy_valid", 32'(bus.OUT_Valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("div_done_valid", 32'(bus.OUT_Valid), 32'd1);

        issue(4'h3, 8'd5, 8'd0, 1, 16'h05FF, 3'b100);
        chk("div0_latency", 32'(bus.OUT_Valid), 32'd1);

        // Backpressure, then drain and accept on the same edge.
        @(posedge clk);
        #1 bus.OUT_Ready = 1'b0;
        issue(4'h1, 8'd10, 8'd5, 1, 16'h0005, 3'b000);
        @(negedge clk);
        bus.ALU_FUN  = 4'h4;
        bus.A        = 8'hF0;
        bus.B        = 8'h3C;
        bus.IN_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.IN_Ready), 32'd0);
            chk("bp_out", 32'(bus.ALU_OUT), 32'h0005);
            @(negedge clk);
        end
        exp_q.push_back('{out: 16'h0030, fl: 3'b000});
        @(posedge clk);
        #1 bus.OUT_Ready = 1'b1;
        @(negedge clk);
        chk("drain_accept_ready", 32'(bus.IN_Ready), 32'd1);
        @(posedge clk);
        #1 bus.IN_Valid = 1'b0;
        chk("after_drain_out", 32'(bus.ALU_OUT), 32'h0030);

        // Reset in the middle of a divide aborts it.
        @(posedge clk);
        issue(4'h3, 8'd200, 8'd3, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.IN_Ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.OUT_Valid), 32'd0);
        chk("mid_rst_out", 32'(bus.ALU_OUT), 32'd0);
        chk("mid_rst_flags", 32'(bus.FLAGS), 32'd0);
        @(negedge clk);
        chk("mid_rst_rel_ready", 32'(bus.IN_Ready), 32'd1);
        repeat (12) @(posedge clk);
        issue(4'h0, 8'd1, 8'd1, 1, 16'h0002, 3'b000);

        repeat (4) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set operand width W (legal W >= 4).
REQ-002 Parameter FUN_WIDTH, default 4, SHALL set opcode width (fixed encoding below uses 4 LSBs).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 RST  input  1  SHALL be a synchronous, active-high reset.
REQ-005 A  input  W  SHALL be operand A (unsigned).
REQ-006 B  input  W  SHALL be operand B (unsigned).
REQ-007 ALU_FUN  input  FUN_WIDTH  SHALL select the operation.
REQ-008 IN_Valid  input  1  SHALL qualify A/B/ALU_FUN.
REQ-009 IN_Ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-010 ALU_OUT  output  2W  SHALL carry the result.
REQ-011 OUT_Valid  output  1  SHALL qualify ALU_OUT and flags.
REQ-012 OUT_Ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-013 FLAGS  output  3  SHALL be {DZ, CARRY, ZERO}, qualified by OUT_Valid.

Function
REQ-014 Accept SHALL occur on a rising edge with IN_Valid=1 and IN_Ready=1; operands and opcode SHALL be captured at accept.
REQ-015 IN_Ready SHALL equal !RST && state!=DIV && (!OUT_Valid || OUT_Ready); same-cycle drain and accept SHALL be supported.
REQ-016 Encoding: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 NAND, 0111 NOR, 1000 NOP, 1001 EQ, 1010 GT, 1011 LT, 1100 A>>1, 1101 A<<1, 1110 B>>1, 1111 B<<1.
REQ-017 ADD SHALL output zero-extended W+1-bit sum; CARRY = bit W of sum.
REQ-018 SUB SHALL output (A-B) mod 2^(W+1) zero-extended to 2W; CARRY = (A<B) borrow.
REQ-019 MUL SHALL output full 2W-bit product.
REQ-020 DIV SHALL output {remainder[W-1:0], quotient[W-1:0]} via iterative restoring division, one quotient bit per cycle.
REQ-021 Logic ops SHALL output W-bit result zero-extended; compare ops SHALL output 1 if true else 0; shifts SHALL be logical by 1, left shift keeps W+1 bits, zero-extended.
REQ-022 NOP SHALL be accepted and consumed without producing OUT_Valid.
REQ-023 ZERO SHALL be 1 iff ALU_OUT==0; CARRY SHALL be 0 for ops other than ADD/SUB; DZ SHALL be 0 except REQ-026.
REQ-024 FSM states IDLE, DIV, HOLD: IDLE->DIV on DIV accept with B!=0; DIV->HOLD after W iteration cycles; any state->HOLD on non-DIV/non-NOP result; HOLD->IDLE when OUT_Ready=1 and no new accept; HOLD stays HOLD on drain+accept of non-DIV op.
REQ-025 Latency: non-DIV ops OUT_Valid on the cycle after accept; DIV with B!=0 OUT_Valid W+1 cycles after accept; IN_Ready=0 for W cycles during DIV.
REQ-026 DIV with B==0 SHALL complete in 1 cycle with quotient all-ones, remainder=A, DZ=1.
REQ-027 While OUT_Valid=1 and OUT_Ready=0, ALU_OUT, FLAGS and OUT_Valid SHALL hold stable.
REQ-028 Opcode bits above bit 3 SHALL be ignored.

Reset
REQ-029 While RST=1 at a rising edge: ALU_OUT=0, FLAGS=0, OUT_Valid=0, state=IDLE, divider registers cleared; IN_Ready=0 while RST=1.
REQ-030 RST asserted mid-division SHALL abort it with no result emitted; IN_Ready=1 the first cycle after RST deasserts.

Verification (W=8)
REQ-031 ADD A=250,B=10, OUT_Ready=1 -> next cycle ALU_OUT=0x0104, CARRY=1, ZERO=0.
REQ-032 MUL A=255,B=255 -> next cycle ALU_OUT=0xFE01; then EQ A=10,B=10 -> ALU_OUT=0x0001.
REQ-033 DIV A=100,B=7 -> IN_Ready=0 for 8 cycles, OUT_Valid 9 cycles after accept, ALU_OUT=0x020E.
REQ-034 DIV A=5,B=0 -> next cycle ALU_OUT=0x05FF, DZ=1.
REQ-035 OUT_Ready=0, SUB 10-5 then AND 0xF0&0x3C offered -> ALU_OUT=0x0005 held, IN_Ready=0; raise OUT_Ready -> AND accepted same edge, next result 0x0030.
REQ-036 RST pulse 3 cycles into DIV 200/3 -> no OUT_Valid, all outputs 0, subsequent ADD 1+1 -> 0x0002.
